// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit(s), one bit per baud tick.
// Define UART_TX_PARITY_EN to include the parity bit (polarity set by PARITY_ODD).
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iBaud_tick,
    input  logic [DATA_BITS-1:0] iData,
    input  logic                 iValid,
    output logic                 oReady,
    output logic                 oTx,
    output logic                 oBusy,
    output logic                 oDone
);

    // state  | meaning
    // IDLE   | line high, ready for a byte
    // SYNC   | byte latched, waiting for the next tick to open the start bit
    // START  | start bit on the line
    // DATA   | data bits, LSB first
    // PARITY | parity bit (only with UART_TX_PARITY_EN)
    // STOP   | stop bit(s); frame ends on the last stop tick
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_t;
`endif

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t               state;
    logic [DATA_BITS-1:0] shreg;
    logic [2:0]           bitcnt;
    logic                 stopcnt;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            shreg   <= '0;
            bitcnt  <= '0;
            stopcnt <= 1'b0;
            oTx     <= 1'b1;
            oReady  <= 1'b1;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    oTx <= 1'b1;
                    if (iValid && oReady) begin
                        shreg  <= iData;
                        bitcnt <= '0;
                        oReady <= 1'b0;
                        oBusy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= (^iData) ^ (PARITY_ODD != 0);
`endif
                        state  <= SYNC;
                    end
                end
                SYNC: begin
                    if (iBaud_tick) begin
                        oTx   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (iBaud_tick) begin
                        oTx   <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (iBaud_tick) begin
                        if (bitcnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            oTx   <= parity_bit;
                            state <= PARITY;
`else
                            oTx     <= 1'b1;
                            stopcnt <= 1'b0;
                            state   <= STOP;
`endif
                        end else begin
                            bitcnt <= bitcnt + 3'd1;
                            oTx    <= shreg[0];
                            shreg  <= shreg >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (iBaud_tick) begin
                        oTx     <= 1'b1;
                        stopcnt <= 1'b0;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    oTx <= 1'b1;
                    if (iBaud_tick) begin
                        if (stopcnt == LAST_STOP) begin
                            stopcnt <= 1'b0;
                            oDone   <= 1'b1;
                            oBusy   <= 1'b0;
                            oReady  <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            stopcnt <= stopcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    oTx    <= 1'b1;
                    oReady <= 1'b1;
                    oBusy  <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer (default, 5-bit/2-stop, and odd-parity instances).
// Expected frames are hand-computed; bit i of each constant is the line level during bit period i.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;

    logic ready_m, tx_m, busy_m, done_m;
    logic ready_5, tx_5, busy_5, done_5;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_m (
        .iClk(clk), .iRst(rst), .iBaud_tick(tick), .iData(data), .iValid(valid),
        .oReady(ready_m), .oTx(tx_m), .oBusy(busy_m), .oDone(done_m));

    uart_tx_serializer #(.DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0)) dut_5 (
        .iClk(clk), .iRst(rst), .iBaud_tick(tick), .iData(data[4:0]), .iValid(valid),
        .oReady(ready_5), .oTx(tx_5), .oBusy(busy_5), .oDone(done_5));

`ifdef UART_TX_PARITY_EN
    logic ready_o, tx_o, busy_o, done_o;
    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut_o (
        .iClk(clk), .iRst(rst), .iBaud_tick(tick), .iData(data), .iValid(valid),
        .oReady(ready_o), .oTx(tx_o), .oBusy(busy_o), .oDone(done_o));

    localparam int          N8   = 11;
    localparam int          N5   = 9;
    localparam logic [15:0] F_A5 = 16'h054A;
    localparam logic [15:0] F_55 = 16'h04AA;
    localparam logic [15:0] F_AA = 16'h0554;
    localparam logic [15:0] F_FF = 16'h05FE;
    localparam logic [15:0] F_1F = 16'h01FE;
`else
    localparam int          N8   = 10;
    localparam int          N5   = 8;
    localparam logic [15:0] F_A5 = 16'h034A;
    localparam logic [15:0] F_55 = 16'h02AA;
    localparam logic [15:0] F_AA = 16'h0354;
    localparam logic [15:0] F_FF = 16'h03FE;
    localparam logic [15:0] F_1F = 16'h00FE;
`endif

    // accept/done monitor on the default instance, for the back-to-back handshake test
    logic mon_on = 1'b0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   acc2_cyc = -1;
    int   done1_cyc = -1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mon_on) begin
            if (valid && ready_m) begin
                acc_cnt <= acc_cnt + 1;
                if (acc_cnt == 1) acc2_cyc <= cyc;
            end
            if (done_m && done1_cyc < 0) done1_cyc <= cyc;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic get(input int sel, output logic tx, output logic dn, output logic rdy, output logic bsy);
        case (sel)
            1: begin tx = tx_5; dn = done_5; rdy = ready_5; bsy = busy_5; end
`ifdef UART_TX_PARITY_EN
            2: begin tx = tx_o; dn = done_o; rdy = ready_o; bsy = busy_o; end
`endif
            default: begin tx = tx_m; dn = done_m; rdy = ready_m; bsy = busy_m; end
        endcase
    endtask

    task automatic pulse();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input string tag, input int sel, input logic [7:0] b);
        logic tx, dn, rdy, bsy;
        @(negedge clk) begin data = b; valid = 1'b1; end
        @(negedge clk) valid = 1'b0;
        get(sel, tx, dn, rdy, bsy);
        check({tag, "_ready_after_accept"}, rdy, 1'b0);
        check({tag, "_busy_after_accept"}, bsy, 1'b1);
    endtask

    // pulse 0 leaves SYNC; pulse i (i<n) opens bit period i; pulse n ends the frame
    task automatic run_frame(input string tag, input int sel, input logic [15:0] exp, input int n);
        logic tx, dn, rdy, bsy;
        for (int i = 0; i <= n; i++) begin
            pulse();
            get(sel, tx, dn, rdy, bsy);
            if (i < n) begin
                check($sformatf("%s_bit%0d", tag, i), tx, exp[i]);
                check($sformatf("%s_nodone%0d", tag, i), dn, 1'b0);
                repeat (14) @(negedge clk);
                get(sel, tx, dn, rdy, bsy);
                check($sformatf("%s_hold%0d", tag, i), tx, exp[i]);
            end else begin
                check({tag, "_done"}, dn, 1'b1);
                check({tag, "_idle_tx"}, tx, 1'b1);
                check({tag, "_ready_end"}, rdy, 1'b1);
                check({tag, "_busy_end"}, bsy, 1'b0);
            end
        end
    endtask

    initial begin
        logic tx, dn, rdy, bsy;

        repeat (3) @(negedge clk);
        check("rst_tx", tx_m, 1'b1);
        check("rst_ready", ready_m, 1'b1);
        check("rst_busy", busy_m, 1'b0);
        check("rst_done", done_m, 1'b0);
        rst = 1'b0;

        // basic frame
        send("t2", 0, 8'hA5);
        run_frame("t2", 0, F_A5, N8);
        do_reset();

`ifdef UART_TX_PARITY_EN
        send("t3e", 0, 8'h07);
        run_frame("t3_even", 0, 16'h060E, 11);
        do_reset();
        send("t3o", 2, 8'h07);
        run_frame("t3_odd", 2, 16'h040E, 11);
        do_reset();
`endif

        // valid held across two frames; data changes while the first frame is in flight
        @(negedge clk) begin mon_on = 1'b1; data = 8'h55; valid = 1'b1; end
        @(negedge clk);
        check("t4_ready_after_accept1", ready_m, 1'b0);
        check("t4_busy_after_accept1", busy_m, 1'b1);
        data = 8'hAA;
        run_frame("t4_f1", 0, F_55, N8);
        @(negedge clk) valid = 1'b0;
        check("t4_ready_after_accept2", ready_m, 1'b0);
        check("t4_busy_after_accept2", busy_m, 1'b1);
        run_frame("t4_f2", 0, F_AA, N8);
        repeat (20) @(negedge clk);
        check("t4_accept_count", acc_cnt, 2);
        check("t4_back_to_back", acc2_cyc, done1_cyc);
        mon_on = 1'b0;
        do_reset();

        // tick coincident with accept must not open the start bit
        @(negedge clk) begin data = 8'hFF; valid = 1'b1; tick = 1'b1; end
        @(negedge clk) begin valid = 1'b0; tick = 1'b0; end
        check("t5_busy", busy_m, 1'b1);
        check("t5_sync_tx", tx_m, 1'b1);
        repeat (14) @(negedge clk);
        check("t5_sync_tx_late", tx_m, 1'b1);
        run_frame("t5", 0, F_FF, N8);
        do_reset();

        // 5 data bits, 2 stop bits
        send("t6", 1, 8'h1F);
        run_frame("t6", 1, F_1F, N5);
        do_reset();

        // reset in the middle of a frame of zeros
        send("t1", 0, 8'h00);
        pulse();
        repeat (14) @(negedge clk);
        pulse();
        check("t1_pre_tx", tx_m, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("t1_tx", tx_m, 1'b1);
        check("t1_ready", ready_m, 1'b1);
        check("t1_busy", busy_m, 1'b0);
        check("t1_done", done_m, 1'b0);
        check("t1_tx5", tx_5, 1'b1);
        check("t1_ready5", ready_5, 1'b1);
        check("t1_busy5", busy_5, 1'b0);
        check("t1_done5", done_5, 1'b0);
`ifdef UART_TX_PARITY_EN
        check("t1_txo", tx_o, 1'b1);
        check("t1_readyo", ready_o, 1'b1);
        check("t1_busyo", busy_o, 1'b0);
        check("t1_doneo", done_o, 1'b0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            pulse();
            get(0, tx, dn, rdy, bsy);
            check($sformatf("t1_after_nodone%0d", i), dn, 1'b0);
            check($sformatf("t1_after_idle%0d", i), tx, 1'b1);
            repeat (14) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
